spi_master: RTL
===============

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter DIV, default 4: sck half-period in clk cycles, legal range 1..255.
REQ-002 Parameter WIDTH, default 8: bits per transaction.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset: synchronous, active-high.
REQ-005 start  input  1  one-cycle request; accepted only when busy=0.
REQ-006 din_tx  input  WIDTH  byte to transmit; captured in the accept cycle.
REQ-007 busy  output  1  high from the cycle after accept until done.
REQ-008 done  output  1  one-cycle pulse at transaction end.
REQ-009 dout_rx  output  WIDTH  received byte; valid from done, held until the next done.
REQ-010 ss  output  1  slave select, active-low.
REQ-011 sck  output  1  serial clock, idle low.
REQ-012 mosi  output  1  serial data out.
REQ-013 miso  input  1  serial data in, asynchronous to clk.

Function
REQ-014 The block SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first, as initiator for the on-chip SPI peripheral.
REQ-015 The FSM SHALL have states IDLE, SETUP, HIGH, LOW, FINISH.
- IDLE -> SETUP: on start with busy=0.
- SETUP -> HIGH: after DIV cycles.
- HIGH -> LOW: after DIV cycles.
- LOW -> HIGH: after DIV cycles while bits remain.
- LOW -> FINISH: after the last bit.
- FINISH -> IDLE: after DIV cycles.
REQ-016 The cycle after accept, the block SHALL drive ss=0 and mosi=din_tx[WIDTH-1], with sck low.
REQ-017 sck SHALL be 1 exactly in HIGH and 0 in all other states.
REQ-018 mosi SHALL change only on entry to LOW, presenting the next bit.
REQ-019 Without the macro (REQ-029), miso SHALL be sampled on the clk edge that enters HIGH.
REQ-020 A bit counter SHALL count WIDTH HIGH phases, and the transaction SHALL end after the WIDTH-th LOW phase.
REQ-021 In FINISH, ss SHALL stay 0, and ss SHALL rise on return to IDLE.
REQ-022 Timing: total busy time SHALL be DIV*(2*WIDTH+2) cycles, with done=1 and busy=0 in the same cycle and dout_rx updated in that cycle.
REQ-023 start while busy=1 SHALL be ignored, with no queuing and no effect on the transfer in progress.
REQ-024 start in the done cycle SHALL be accepted, giving back-to-back transfers with ss high for exactly 1 cycle.
REQ-025 din_tx changes after accept SHALL NOT affect the transfer in progress.

Reset
REQ-026 On rst=1 in any state, the next cycle SHALL show state IDLE, ss=1, sck=0, mosi=0, busy=0, done=0, dout_rx=0, and all counters cleared.
REQ-027 Reset mid-transfer SHALL abort with no done pulse, and the partial received byte SHALL be discarded.
REQ-028 rst SHALL take priority over start in the same cycle.

Configuration
REQ-029 Macro SPI_MASTER_MISO_SYNC_EN defined: miso SHALL pass through a 2-flop synchronizer and be sampled in the last clk cycle of HIGH, and DIV SHALL be >=3 (elaboration error otherwise).
REQ-030 Macro undefined: there SHALL be no synchronizer, sampling SHALL follow REQ-019, and DIV>=1.
REQ-031 Transaction length and port list SHALL be identical in both builds.

Structure
REQ-032 Package spi_master_pkg SHALL hold the FSM state enum, DEFAULT_DIV=4, and DEFAULT_WIDTH=8.
REQ-033 Sub-module spi_sck_gen SHALL hold the half-period counter, emitting a 1-cycle tick every DIV cycles while enabled and resetting its count on enable rise.
REQ-034 Total RTL size SHALL be 120-400 lines.

Verification
REQ-035 DIV=4, din_tx=0xA5, slave model drives miso=0x3C -> mosi bits 1,0,1,0,0,1,0,1; dout_rx=0x3C; done exactly 72 cycles after accept.
REQ-036 mosi looped to miso, din_tx in {0x00, 0xFF, 0x5A} -> dout_rx equals din_tx each time.
REQ-037 start pulsed 10 cycles into a transfer -> no change to sck/mosi, single done, busy continuous.
REQ-038 rst at cycle 30 of a 72-cycle transfer -> next cycle ss=1, sck=0, busy=0; no done; dout_rx=0.
REQ-039 start held high through done -> second transfer begins; ss high for exactly 1 cycle between ss-low windows.
REQ-040 SPI_MASTER_MISO_SYNC_EN defined, DIV=4, miso changing 1 cycle after sck rises -> dout_rx correct; DIV=2 build -> elaboration error.

Source files
------------

// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI mode-0 initiator: default geometry and FSM state encoding.
package spi_master_pkg;

    localparam int DEFAULT_DIV   = 4;
    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_HIGH   = 3'd2,
        ST_LOW    = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    // Plain constants for the state register, kept bit-identical to state_e.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_HIGH   = 3'd2;
    localparam logic [2:0] S_LOW    = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

endpackage

// File: rtl/spi_master_if.sv
// Request/response and serial pins of the SPI initiator, seen from both sides.
interface spi_master_if
    import spi_master_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] din_tx;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout_rx;
    logic             ss;
    logic             sck;
    logic             mosi;
    logic             miso;

    modport master (
        input  start, din_tx, miso,
        output busy, done, dout_rx, ss, sck, mosi
    );

    modport slave (
        output start, din_tx, miso,
        input  busy, done, dout_rx, ss, sck, mosi
    );

endinterface

// File: rtl/spi_sck_gen.sv
// Half-period timer: one-cycle tick every DIV clk cycles while enabled; count restarts whenever en is low.
module spi_sck_gen
    import spi_master_pkg::*;
#(
    parameter int DIV = DEFAULT_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator, MSB first, one WIDTH-bit transfer per accepted start.
// Build option SPI_MASTER_MISO_SYNC_EN: 2-flop miso synchronizer, sampled at the end of sck high (DIV>=3).
module spi_master
    import spi_master_pkg::*;
#(
    parameter int DIV   = DEFAULT_DIV,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic          clk,
    input logic          rst,
    spi_master_if.master bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH);

    logic [2:0]       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] tx_sr;
    logic [WIDTH-1:0] rx_sr;
    logic [WIDTH-1:0] dout_q;
    logic             done_q;
    logic             tick;
    logic             miso_q;
    logic             sample;

    generate
        if (DIV < 1 || DIV > 255) begin : g_div_range
            $error("spi_master: DIV must be in 1..255");
        end
    endgenerate

`ifdef SPI_MASTER_MISO_SYNC_EN
    logic [1:0] miso_sync;

    generate
        if (DIV < 3) begin : g_div_sync
            $error("spi_master: DIV must be >= 3 with the miso synchronizer");
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            miso_sync <= '0;
        end else begin
            miso_sync <= {miso_sync[0], bus.miso};
        end
    end

    // Late sampling leaves the two synchronizer stages time to settle within the high phase.
    assign miso_q = miso_sync[1];
    assign sample = tick && (state == S_HIGH);
`else
    assign miso_q = bus.miso;
    assign sample = tick && ((state == S_SETUP) ||
                             ((state == S_LOW) && (bit_cnt != LAST_BIT)));
`endif

    spi_sck_gen #(.DIV(DIV)) u_sck_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state != S_IDLE),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            tx_sr   <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state   <= S_SETUP;
                        tx_sr   <= bus.din_tx;
                        bit_cnt <= '0;
                    end
                end
                S_SETUP: begin
                    if (tick) begin
                        state   <= S_HIGH;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (tick) begin
                        state <= S_LOW;
                        tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
                    end
                end
                S_LOW: begin
                    if (tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            state <= S_FINISH;
                        end else begin
                            state   <= S_HIGH;
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                S_FINISH: begin
                    if (tick) begin
                        state  <= S_IDLE;
                        done_q <= 1'b1;
                        dout_q <= rx_sr;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Reset also clears the partial byte so an aborted transfer leaves nothing behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sr <= '0;
        end else if (sample) begin
            rx_sr <= {rx_sr[WIDTH-2:0], miso_q};
        end
    end

    assign bus.busy    = (state != S_IDLE);
    assign bus.done    = done_q;
    assign bus.dout_rx = dout_q;
    assign bus.ss      = (state == S_IDLE);
    assign bus.sck     = (state == S_HIGH);
    assign bus.mosi    = tx_sr[WIDTH-1];

endmodule
